// File: rtl/cfar_sched_pkg.sv
// Shared definitions for the CFAR row scheduler and the histogram engine it feeds.
package cfar_sched_pkg;

  // Widths shared with the histogram/threshold engine
  localparam int ROW_NUM_W = 12;
  localparam int AMP_W     = 8;

  // Threshold reported when the engine never answers for a row
  localparam logic [AMP_W-1:0] TH_TIMEOUT_VAL = 8'hFF;

  // Scheduler state machine
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_BURST     = 3'd2,
    ST_WAIT_HIST = 3'd3,
    ST_GAP       = 3'd4,
    ST_DONE      = 3'd5
  } sched_state_e;

endpackage

// File: rtl/hist_row_scheduler.sv
// Moves one full range-Doppler row at a time from the RDM FIFO into the
// histogram engine, then waits for that row's threshold and tags it.
module hist_row_scheduler
  import cfar_sched_pkg::*;
#(
  parameter int ROW_LEN_W   = 10,
  parameter int ROWS_W      = ROW_NUM_W,
  parameter int FIFO_CNT_W  = 11,
  parameter int TIMEOUT_CYC = 128,
  parameter int MIN_GAP     = 2
) (
  input  logic                  clk_100mhz,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic [ROW_LEN_W-1:0]  cfg_row_len,
  input  logic [ROWS_W-1:0]     cfg_num_rows,
  input  logic [AMP_W-1:0]      fifo_dout,
  input  logic                  fifo_empty,
  input  logic [FIFO_CNT_W-1:0] fifo_count,
  output logic                  fifo_rd_en,
  output logic                  rdm_data_tvalid,
  output logic [AMP_W-1:0]      rdm_amp_data,
  input  logic                  histogram_calc_vld,
  input  logic [AMP_W-1:0]      histogram_calc_datath,
  output logic                  th_valid,
  output logic [AMP_W-1:0]      th_data,
  output logic [ROWS_W-1:0]     th_row,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_timeout,
  output logic                  err_underflow,
  output logic                  err_spurious
);

  localparam int TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(MIN_GAP - 1);

  sched_state_e          state_q, state_d;
  logic [ROW_LEN_W-1:0]  row_len_q, row_len_d;
  logic [ROWS_W-1:0]     num_rows_q, num_rows_d;
  logic [ROWS_W-1:0]     row_idx_q, row_idx_d;
  logic [ROW_LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  tvalid_q, tvalid_d;
  logic [AMP_W-1:0]      amp_q, amp_d;
  logic                  th_valid_q, th_valid_d;
  logic [AMP_W-1:0]      th_data_q, th_data_d;
  logic [ROWS_W-1:0]     th_row_q, th_row_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_to_q, err_to_d;
  logic                  err_uf_q, err_uf_d;
  logic                  err_sp_q, err_sp_d;

  logic pop;
  logic row_ready;
  logic hist_timeout;

  // Pop whenever a burst is in progress and the FIFO head is valid
  assign pop          = (state_q == ST_BURST) && !fifo_empty;
  assign row_ready    = (fifo_count >= FIFO_CNT_W'(row_len_q)) && !fifo_empty;
  assign hist_timeout = (timer_q == TIMEOUT_LAST);

  // Next-state and datapath decisions for the row sequencer
  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    row_idx_d  = row_idx_q;
    beat_cnt_d = beat_cnt_q;
    timer_d    = timer_q;
    th_valid_d = 1'b0;
    th_data_d  = th_data_q;
    th_row_d   = th_row_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_to_d   = err_to_q;
    err_uf_d   = err_uf_q;
    err_sp_d   = err_sp_q;
    tvalid_d   = pop;
    amp_d      = pop ? fifo_dout : '0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          row_len_d  = cfg_row_len;
          num_rows_d = cfg_num_rows;
          row_idx_d  = '0;
          busy_d     = 1'b1;
          err_to_d   = 1'b0;
          err_uf_d   = 1'b0;
          err_sp_d   = 1'b0;
          // A zero-sized frame finishes without touching the FIFO
          if ((cfg_row_len == '0) || (cfg_num_rows == '0)) state_d = ST_DONE;
          else                                             state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (row_ready) begin
          state_d    = ST_BURST;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        // Underflow stalls the burst; the row is still completed afterwards
        if (fifo_empty) begin
          err_uf_d = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + ROW_LEN_W'(1);
          if (beat_cnt_q == row_len_q - ROW_LEN_W'(1)) begin
            state_d = ST_WAIT_HIST;
            timer_d = '0;
          end
        end
      end
      ST_WAIT_HIST: begin
        timer_d = timer_q + TIMER_W'(1);
        if (histogram_calc_vld || hist_timeout) begin
          th_valid_d = 1'b1;
          th_row_d   = row_idx_q;
          // A real threshold beats a simultaneous timeout
          if (histogram_calc_vld) begin
            th_data_d = histogram_calc_datath;
          end else begin
            th_data_d = TH_TIMEOUT_VAL;
            err_to_d  = 1'b1;
          end
          if (row_idx_q == num_rows_q - ROWS_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            row_idx_d = row_idx_q + ROWS_W'(1);
            state_d   = ST_GAP;
            timer_d   = '0;
          end
        end
      end
      ST_GAP: begin
        // Guarantees the engine sees tvalid low between rows
        timer_d = timer_q + TIMER_W'(1);
        if (timer_q == GAP_LAST) state_d = ST_WAIT_DATA;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Engine strobes only make sense while a row threshold is pending
    if (histogram_calc_vld && (state_q != ST_WAIT_HIST)) err_sp_d = 1'b1;
  end

  // State and output registers, cleared by the synchronous active-low reset
  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      row_idx_q  <= '0;
      beat_cnt_q <= '0;
      timer_q    <= '0;
      tvalid_q   <= 1'b0;
      amp_q      <= '0;
      th_valid_q <= 1'b0;
      th_data_q  <= '0;
      th_row_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_uf_q   <= 1'b0;
      err_sp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      row_idx_q  <= row_idx_d;
      beat_cnt_q <= beat_cnt_d;
      timer_q    <= timer_d;
      tvalid_q   <= tvalid_d;
      amp_q      <= amp_d;
      th_valid_q <= th_valid_d;
      th_data_q  <= th_data_d;
      th_row_q   <= th_row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_to_q   <= err_to_d;
      err_uf_q   <= err_uf_d;
      err_sp_q   <= err_sp_d;
    end
  end

  assign fifo_rd_en      = pop;
  assign rdm_data_tvalid = tvalid_q;
  assign rdm_amp_data    = amp_q;
  assign th_valid        = th_valid_q;
  assign th_data         = th_data_q;
  assign th_row          = th_row_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign err_timeout     = err_to_q;
  assign err_underflow   = err_uf_q;
  assign err_spurious    = err_sp_q;

endmodule
